ram_wb_arbiter: RTL and testbench
=================================

# ram_wb_arbiter

Two-master Wishbone arbiter placed in front of the on-chip RAM slave (`ram_top`), letting the OR1200 instruction bus (m0) and data bus (m1) share a single RAM port. It grants one master at a time with round-robin priority. It passes the granted master's cycle through to the slave and routes the slave's ack back. Between grants it forces a one-cycle idle on the slave request, because the RAM only acks on a rising edge of stb&cyc.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `TMO`, 15, watchdog limit in cycles from slave request to ack (used only with `RAM_ARB_WDT_EN`); 4-bit counter

Ports:
- `clk_i`  in  1  single clock, all logic on rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `m0_stb_i`, `m0_cyc_i`, `m0_we_i`  in  1 each  master 0 Wishbone controls
- `m0_addr_i`  in  AW;  `m0_sel_i`  in  4;  `m0_data_i`  in  DW
- `m0_data_o`  out  DW;  `m0_ack_o`  out  1;  `m0_err_o`  out  1
- `m1_*`  identical set for master 1
- `s_stb_o`, `s_cyc_o`, `s_we_o`  out  1 each  to RAM slave
- `s_addr_o`  out  AW;  `s_sel_o`  out  4;  `s_data_o`  out  DW
- `s_data_i`  in  DW;  `s_ack_i`  in  1  from RAM slave

## Operation
- Request: `mX_req = mX_stb_i & mX_cyc_i`.
- FSM states:
  - IDLE: slave request low.
  - BUSY: grant held, slave driven from the granted master.
  - GAP: slave request low for exactly one cycle.
  - DRAIN: slave request low, late acks swallowed.
- Transitions:
  - IDLE or GAP, any request present -> BUSY with the selected master; no request -> IDLE.
  - BUSY, `s_ack_i` high -> GAP.
  - BUSY, granted master drops its request before ack (abort) -> DRAIN.
  - BUSY, watchdog expires -> DRAIN.
  - DRAIN -> IDLE once the drain counter reaches 3 cycles.
- Arbitration:
  - Only one master requesting: that master wins.
  - Both requesting: the master that was not granted last (`last_gnt`) wins.
  - `last_gnt` resets to 1, so m0 wins the first tie.
  - `last_gnt` updates on entry to BUSY.
- Slave mux in BUSY:
  - Outputs are the granted master's addr/sel/we/data, with stb/cyc = that master's stb/cyc.
  - Outside BUSY, all slave outputs are 0.
- Return path:
  - `s_data_i` is broadcast to both `mX_data_o`.
  - `mX_ack_o = s_ack_i` only when in BUSY and granted to X; otherwise 0.
- In DRAIN, any `s_ack_i` is dropped and never reaches a master.
- The non-granted master simply waits; its signals are ignored and it gets no ack/err.

## Timing
- Reset (async): state IDLE, `last_gnt`=1, counters 0.
  - All outputs 0: all `s_*_o`, `mX_ack_o`, `mX_err_o`.
  - `mX_data_o` = `s_data_i` (combinational).
- Grant latency:
  - Request sampled at the end of cycle 0; BUSY from cycle 1.
  - Slave stb/cyc high in cycle 1.
  - With `ram_top`, `s_ack_i` and `mX_ack_o` are high in cycle 3.
  - GAP in cycle 4; the next grant takes effect in cycle 5.
- Ack: combinational pass-through, exactly 1 cycle wide, in the same cycle as `s_ack_i`.
- Back-to-back requests from one master, with the other idle: 4-cycle spacing between acks, single-master throughput 1 transfer / 4 cycles.
- Simultaneous arrival at the GAP cycle: round-robin rule applies, so after an m0 transfer a pending m1 is granted.
- Async reset mid-transfer: the slave request drops immediately; no ack is produced.

## Configuration
- `RAM_ARB_WDT_EN` defined:
  - A 4-bit counter runs in BUSY; it clears on BUSY entry.
  - If `s_ack_i` has not been seen after `TMO` cycles, the granted master's `mX_err_o` pulses high for 1 cycle, no ack is given, and the FSM enters DRAIN.
- `RAM_ARB_WDT_EN` undefined:
  - No counter; BUSY waits indefinitely (only ack or abort exits).
  - `mX_err_o` is tied to 0.

## Test plan
- m0 single read at addr 0x100, m1 idle -> `s_stb_o` high in cycle 1, `m0_ack_o` in cycle 3 with the RAM word, `m1_ack_o` stays 0.
- m0 and m1 both request in the same cycle, and keep requesting after each ack -> grant order m0, m1, m0, m1; each ack reaches only its owner; slave stb low for one GAP cycle between transfers.
- m1 write 0xDEADBEEF with sel=4'b0011, then m0 read of the same address -> read returns 0x0000BEEF over the initial zero contents.
- m0 aborts (cyc low) in cycle 2 -> FSM enters DRAIN; the slave ack in cycle 3 is not forwarded; an m1 request is granted only after DRAIN completes.
- With `RAM_ARB_WDT_EN` and the slave ack tied low -> `m0_err_o` pulses once in cycle 1+`TMO` (16), then DRAIN, then IDLE.
- `rst_i` asserted while in BUSY -> `s_cyc_o`/`s_stb_o` go low in the same cycle, `last_gnt`=1, and the first tie after reset goes to m0.

Source files
------------

// File: rtl/ram_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the on-chip RAM slave.
// Optional request-to-ack watchdog is enabled by defining RAM_ARB_WDT_EN.
module ram_wb_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_stb_i,
    input  logic          m0_cyc_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [3:0]    m0_sel_i,
    input  logic [DW-1:0] m0_data_i,
    output logic [DW-1:0] m0_data_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic          m1_stb_i,
    input  logic          m1_cyc_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [3:0]    m1_sel_i,
    input  logic [DW-1:0] m1_data_i,
    output logic [DW-1:0] m1_data_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic          s_stb_o,
    output logic          s_cyc_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_addr_o,
    output logic [3:0]    s_sel_o,
    output logic [DW-1:0] s_data_o,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_ack_i
);

    typedef enum logic [1:0] {IDLE, BUSY, GAP, DRAIN} state_t;

    localparam logic [3:0] TMO_C = 4'(TMO);

    state_t     state;
    logic       last_gnt;
    logic [1:0] drain_cnt;
    logic       m0_req;
    logic       m1_req;
    logic       any_req;
    logic       pick;
    logic       gnt_req;
    logic       busy;
    logic       wdt_expire;

    assign m0_req  = m0_stb_i & m0_cyc_i;
    assign m1_req  = m1_stb_i & m1_cyc_i;
    assign any_req = m0_req | m1_req;
    // On a tie the master that did not win last time is picked
    assign pick    = (m0_req & m1_req) ? ~last_gnt : ~m0_req;
    assign gnt_req = last_gnt ? m1_req : m0_req;
    assign busy    = (state == BUSY);

`ifdef RAM_ARB_WDT_EN
    logic [3:0] wdt_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdt_cnt <= 4'd0;
        end else if (!busy) begin
            wdt_cnt <= 4'd0;
        end else if (wdt_cnt != TMO_C) begin
            wdt_cnt <= wdt_cnt + 4'd1;
        end
    end

    assign wdt_expire = busy & (wdt_cnt == TMO_C) & ~s_ack_i;
`else
    assign wdt_expire = 1'b0 & (TMO_C == 4'd0);
`endif

    // last_gnt doubles as the current grant while in BUSY
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            drain_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (any_req) begin
                        state    <= BUSY;
                        last_gnt <= pick;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (s_ack_i) begin
                        state <= GAP;
                    end else if (!gnt_req || wdt_expire) begin
                        state     <= DRAIN;
                        drain_cnt <= 2'd0;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'd2) begin
                        state     <= IDLE;
                        drain_cnt <= 2'd0;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_sel_o  = 4'd0;
        s_data_o = '0;
        if (busy) begin
            if (last_gnt) begin
                s_stb_o  = m1_stb_i;
                s_cyc_o  = m1_cyc_i;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_sel_o  = m1_sel_i;
                s_data_o = m1_data_i;
            end else begin
                s_stb_o  = m0_stb_i;
                s_cyc_o  = m0_cyc_i;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_sel_o  = m0_sel_i;
                s_data_o = m0_data_i;
            end
        end
    end

    // Acks outside BUSY (e.g. late acks during DRAIN) never reach a master
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign m0_ack_o  = busy & ~last_gnt & s_ack_i;
    assign m1_ack_o  = busy & last_gnt & s_ack_i;
    assign m0_err_o  = wdt_expire & ~last_gnt;
    assign m1_err_o  = wdt_expire & last_gnt;

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Directed bench for ram_wb_arbiter with a small behavioural model of ram_top.
// Cycle 0 of each scenario is the first cycle after the DUT leaves reset.
module tb_ram_wb_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_stb, m0_cyc, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdat, m0_rdat;
    logic [3:0]  m0_sel;
    logic        m1_stb, m1_cyc, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdat, m1_rdat;
    logic [3:0]  m1_sel;
    logic        s_stb, s_cyc, s_we, s_ack;
    logic [31:0] s_addr, s_wdat;
    logic [31:0] s_rdat = 32'h1234_5678;
    logic [3:0]  s_sel;

    int checks = 0;
    int errors = 0;
    logic ack_en = 1'b1;

    ram_wb_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
        .m0_sel_i(m0_sel), .m0_data_i(m0_wdat), .m0_data_o(m0_rdat), .m0_ack_o(m0_ack),
        .m0_err_o(m0_err),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
        .m1_sel_i(m1_sel), .m1_data_i(m1_wdat), .m1_data_o(m1_rdat), .m1_ack_o(m1_ack),
        .m1_err_o(m1_err),
        .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_we_o(s_we), .s_addr_o(s_addr),
        .s_sel_o(s_sel), .s_data_o(s_wdat), .s_data_i(s_rdat), .s_ack_i(s_ack)
    );

    // RAM model: acks two cycles after a rising edge of stb&cyc
    logic [31:0] mem [0:255];
    logic        req_d, p1, p_we;
    logic [7:0]  p_idx;
    logic [3:0]  p_sel;
    logic [31:0] p_data;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        merge = old;
        for (int b = 0; b < 4; b++)
            if (sel[b]) merge[8*b +: 8] = d[8*b +: 8];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            req_d <= 1'b0;
            p1    <= 1'b0;
            s_ack <= 1'b0;
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            mem[64] <= 32'hA5A5_1234;
        end else begin
            req_d <= s_stb & s_cyc;
            p1    <= s_stb & s_cyc & ~req_d & ack_en;
            s_ack <= p1;
            if (s_stb & s_cyc & ~req_d) begin
                p_idx  <= s_addr[9:2];
                p_we   <= s_we;
                p_sel  <= s_sel;
                p_data <= s_wdat;
            end
            if (p1) begin
                s_rdat <= mem[p_idx];
                if (p_we) mem[p_idx] <= merge(mem[p_idx], p_data, p_sel);
            end
        end
    end

    task automatic idle_masters;
        m0_stb = 0; m0_cyc = 0; m0_we = 0; m0_addr = 0; m0_sel = 4'hF; m0_wdat = 0;
        m1_stb = 0; m1_cyc = 0; m1_we = 0; m1_addr = 0; m1_sel = 4'hF; m1_wdat = 0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        ack_en = 1'b1;
        idle_masters();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_masters();
        m0_stb = 1; m0_cyc = 1; m1_stb = 1; m1_cyc = 1; m1_we = 1; m1_addr = 32'h40;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_stb, s_cyc, s_we} !== 3'b000) begin
            errors++; $display("FAIL reset_s_ctl got %b want 000", {s_stb, s_cyc, s_we});
        end
        checks++;
        if ({s_addr, s_sel, s_wdat} !== 68'd0) begin
            errors++; $display("FAIL reset_s_bus got %h want 0", {s_addr, s_sel, s_wdat});
        end
        checks++;
        if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_ack_err got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err});
        end
        checks++;
        if (m0_rdat !== 32'h1234_5678 || m1_rdat !== 32'h1234_5678) begin
            errors++; $display("FAIL reset_data_pass got %h/%h want 12345678", m0_rdat, m1_rdat);
        end
        idle_masters();
    endtask

    task automatic test_read_back_to_back;
        logic [15:0] stb_exp = 16'h0EEE;
        logic [15:0] ack_exp = 16'h0888;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin m0_stb = 1; m0_cyc = 1; m0_addr = 32'h100; end
            @(negedge clk);
            checks++;
            if (s_stb !== stb_exp[c]) begin
                errors++; $display("FAIL b2b_stb c%0d got %b want %b", c, s_stb, stb_exp[c]);
            end
            checks++;
            if (m0_ack !== ack_exp[c] || m1_ack !== 1'b0) begin
                errors++; $display("FAIL b2b_ack c%0d got %b%b want %b0", c, m0_ack, m1_ack, ack_exp[c]);
            end
            if (ack_exp[c]) begin
                checks++;
                if (m0_rdat !== 32'hA5A5_1234) begin
                    errors++; $display("FAIL b2b_data c%0d got %h want a5a51234", c, m0_rdat);
                end
            end
        end
        idle_masters();
    endtask

    task automatic test_round_robin;
        logic [15:0] stb_exp = 16'hEEEE;
        logic [15:0] a0_exp  = 16'h0808;
        logic [15:0] a1_exp  = 16'h8080;
        logic [15:0] m1_own  = 16'hE0E0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                m0_stb = 1; m0_cyc = 1; m0_addr = 32'h10;
                m1_stb = 1; m1_cyc = 1; m1_addr = 32'h20;
            end
            @(negedge clk);
            checks++;
            if (s_stb !== stb_exp[c]) begin
                errors++; $display("FAIL rr_stb c%0d got %b want %b", c, s_stb, stb_exp[c]);
            end
            checks++;
            if ({m0_ack, m1_ack} !== {a0_exp[c], a1_exp[c]}) begin
                errors++; $display("FAIL rr_ack c%0d got %b%b want %b%b", c, m0_ack, m1_ack, a0_exp[c], a1_exp[c]);
            end
            checks++;
            if ({m0_err, m1_err} !== 2'b00) begin
                errors++; $display("FAIL rr_err c%0d got %b%b want 00", c, m0_err, m1_err);
            end
            if (stb_exp[c]) begin
                checks++;
                if (s_addr !== (m1_own[c] ? 32'h20 : 32'h10)) begin
                    errors++; $display("FAIL rr_addr c%0d got %h want %h", c, s_addr, m1_own[c] ? 32'h20 : 32'h10);
                end
            end
        end
        idle_masters();
    endtask

    task automatic test_write_read;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                m1_stb = 1; m1_cyc = 1; m1_we = 1; m1_addr = 32'h40;
                m1_wdat = 32'hDEAD_BEEF; m1_sel = 4'b0011;
            end
            if (c == 4) begin
                m1_stb = 0; m1_cyc = 0; m1_we = 0;
                m0_stb = 1; m0_cyc = 1; m0_addr = 32'h40; m0_sel = 4'hF;
            end
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if ({s_we, s_sel, s_addr, s_wdat} !== {1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF}) begin
                    errors++; $display("FAIL wr_bus got we=%b sel=%b a=%h d=%h want 1/0011/40/deadbeef", s_we, s_sel, s_addr, s_wdat);
                end
            end
            if (c == 3) begin
                checks++;
                if ({m0_ack, m1_ack} !== 2'b01) begin
                    errors++; $display("FAIL wr_ack got %b%b want 01", m0_ack, m1_ack);
                end
            end
            if (c == 5) begin
                checks++;
                if ({s_stb, s_we, s_addr} !== {1'b1, 1'b0, 32'h40}) begin
                    errors++; $display("FAIL rd_bus got stb=%b we=%b a=%h want 1/0/40", s_stb, s_we, s_addr);
                end
            end
            if (c == 7) begin
                checks++;
                if ({m0_ack, m1_ack} !== 2'b10 || m0_rdat !== 32'h0000_BEEF) begin
                    errors++; $display("FAIL rd_data got ack=%b%b d=%h want 10/0000beef", m0_ack, m1_ack, m0_rdat);
                end
            end
        end
        idle_masters();
    endtask

    task automatic test_abort;
        logic [15:0] stb_exp = 16'h0386;
        logic [15:0] a1_exp  = 16'h0200;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin m0_stb = 1; m0_cyc = 1; m0_addr = 32'h100; end
            if (c == 2) begin m0_cyc = 0; m1_stb = 1; m1_cyc = 1; m1_addr = 32'h20; end
            if (c == 3) m0_stb = 0;
            @(negedge clk);
            checks++;
            if (s_stb !== stb_exp[c]) begin
                errors++; $display("FAIL abort_stb c%0d got %b want %b", c, s_stb, stb_exp[c]);
            end
            checks++;
            if ({m0_ack, m1_ack} !== {1'b0, a1_exp[c]}) begin
                errors++; $display("FAIL abort_ack c%0d got %b%b want 0%b", c, m0_ack, m1_ack, a1_exp[c]);
            end
            if (c == 2) begin
                checks++;
                if (s_cyc !== 1'b0) begin
                    errors++; $display("FAIL abort_cyc got %b want 0", s_cyc);
                end
            end
            if (c == 7) begin
                checks++;
                if (s_addr !== 32'h20) begin
                    errors++; $display("FAIL abort_m1_addr got %h want 00000020", s_addr);
                end
            end
        end
        idle_masters();
    endtask

    task automatic test_reset_busy;
        logic [15:0] stb_exp = 16'h00E2;
        logic [15:0] a0_exp  = 16'h0080;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                m0_stb = 1; m0_cyc = 1; m0_addr = 32'h10;
                m1_stb = 1; m1_cyc = 1; m1_addr = 32'h20;
            end
            if (c == 2) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({s_stb, s_cyc} !== 2'b00) begin
                    errors++; $display("FAIL rstbusy_drop got %b%b want 00", s_stb, s_cyc);
                end
            end
            if (c == 4) rst = 1'b0;
            @(negedge clk);
            checks++;
            if (s_stb !== stb_exp[c]) begin
                errors++; $display("FAIL rstbusy_stb c%0d got %b want %b", c, s_stb, stb_exp[c]);
            end
            checks++;
            if ({m0_ack, m1_ack} !== {a0_exp[c], 1'b0}) begin
                errors++; $display("FAIL rstbusy_ack c%0d got %b%b want %b0", c, m0_ack, m1_ack, a0_exp[c]);
            end
            if (c == 5) begin
                checks++;
                if (s_addr !== 32'h10) begin
                    errors++; $display("FAIL rstbusy_tie got %h want 00000010", s_addr);
                end
            end
        end
        idle_masters();
    endtask

`ifdef RAM_ARB_WDT_EN
    task automatic test_watchdog;
        do_reset();
        ack_en = 1'b0;
        for (int c = 0; c < 22; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin m0_stb = 1; m0_cyc = 1; m0_addr = 32'h100; end
            if (c == 17) idle_masters();
            @(negedge clk);
            checks++;
            if ({m0_err, m1_err, m0_ack} !== {(c == 16), 1'b0, 1'b0}) begin
                errors++; $display("FAIL wdt c%0d got err=%b%b ack=%b want %b00", c, m0_err, m1_err, m0_ack, (c == 16));
            end
            checks++;
            if (s_stb !== (c >= 1 && c <= 16)) begin
                errors++; $display("FAIL wdt_stb c%0d got %b want %b", c, s_stb, (c >= 1 && c <= 16));
            end
        end
        ack_en = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle_masters();
        test_reset();
        test_read_back_to_back();
        test_round_robin();
        test_write_read();
        test_abort();
        test_reset_busy();
`ifdef RAM_ARB_WDT_EN
        test_watchdog();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
